// File: rtl/mem_stall_ctrl_if.sv
// Data-memory bus between the MEM-stage stall controller (master) and memory (slave).
// Handshake: mem_req_o rises and is held with a stable mem_we_o until memory returns a one-cycle mem_ack_i pulse; mem_rdata_i is valid only in that ack cycle.
interface mem_stall_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// MEM-stage memory access sequencer and global pipeline-advance enable.
// Define MEM_STALL_PERF_EN to build the saturating stall-cycle counter on stall_cnt_o.
module mem_stall_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    mem_stall_ctrl_if.master   mem,
    output logic               pipe_en_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               err_o,
    output logic [31:0]        stall_cnt_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              memop;

    assign memop   = MemRead_i | MemWrite_i;
    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_req_o <= 1'b0;
            mem.mem_we_o  <= 1'b0;
            rdata_o       <= '0;
            err_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && memop) begin
                        state         <= ACCESS;
                        mem.mem_req_o <= 1'b1;
                        mem.mem_we_o  <= MemWrite_i;
                        cnt           <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // Ack wins even on the last allowed cycle.
                    if (mem.mem_ack_i) begin
                        state         <= DONE;
                        mem.mem_req_o <= 1'b0;
                        if (!mem.mem_we_o) rdata_o <= mem.mem_rdata_i;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state         <= ERR;
                        mem.mem_req_o <= 1'b0;
                        err_o         <= 1'b1;
                    end
                end
                DONE: begin
                    // The pipeline advances on this edge, so the finished op leaves EX/MEM.
                    if (start_i) state <= IDLE;
                end
                ERR: begin
                    state <= ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_en_o = 1'b0;
        case (state)
            IDLE:    pipe_en_o = start_i & ~memop;
            DONE:    pipe_en_o = start_i;
            default: pipe_en_o = 1'b0;
        endcase
    end

`ifdef MEM_STALL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (start_i && !pipe_en_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: load/store latency, timeout, DONE hold, reset, stall counter.
module tb_mem_stall_ctrl;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        pipe_en_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;
    logic [1:0]  state_o;

    int n_chk;
    int n_fail;
    logic [31:0] exp_rd;

    mem_stall_ctrl_if #(.DATA_W(32)) mif ();

    mem_stall_ctrl #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .mem         (mif),
        .pipe_en_o   (pipe_en_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o),
        .state_o     (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One memory op with ack in ACCESS cycle k; start_i held high throughout.
    task automatic mem_op(input logic rd, input logic wr, input int k, input logic [31:0] d);
        MemRead_i  = rd;
        MemWrite_i = wr;
        start_i    = 1'b1;
        #1;
        check("idle_memop_pipe_en", {31'd0, pipe_en_o}, 32'd0);
        for (int i = 1; i <= k; i++) begin
            tick();
            check("access_req", {31'd0, mif.mem_req_o}, 32'd1);
            check("access_we", {31'd0, mif.mem_we_o}, {31'd0, wr});
            check("access_pipe_en", {31'd0, pipe_en_o}, 32'd0);
            if (i == k) begin
                mif.mem_ack_i   = 1'b1;
                mif.mem_rdata_i = d;
            end
        end
        tick();
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = $urandom;
        if (!wr) exp_rd = d;
        #1;
        check("done_state", {30'd0, state_o}, {30'd0, S_DONE});
        check("done_pipe_en", {31'd0, pipe_en_o}, 32'd1);
        check("done_req", {31'd0, mif.mem_req_o}, 32'd0);
        check("done_rdata", rdata_o, exp_rd);
        check("done_err", {31'd0, err_o}, 32'd0);
        tick();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        #1;
        check("back_idle_state", {30'd0, state_o}, {30'd0, S_IDLE});
        check("back_idle_pipe_en", {31'd0, pipe_en_o}, 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        tick();
        rst_i = 1'b1;
        exp_rd = 32'd0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_rd = 32'd0;
        rst_i = 1'b0;
        start_i = 1'b0;
        MemRead_i = 1'b0;
        MemWrite_i = 1'b0;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = 32'd0;
        tick();
        tick();
        check("rst_state", {30'd0, state_o}, {30'd0, S_IDLE});
        check("rst_req", {31'd0, mif.mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mif.mem_we_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        rst_i = 1'b1;

        // start_i low with a pending load: no launch
        MemRead_i = 1'b1;
        tick();
        check("no_start_state", {30'd0, state_o}, {30'd0, S_IDLE});
        check("no_start_req", {31'd0, mif.mem_req_o}, 32'd0);
        check("no_start_pipe_en", {31'd0, pipe_en_o}, 32'd0);

        // ack in IDLE is ignored
        MemRead_i = 1'b0;
        start_i = 1'b1;
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h5555_AAAA;
        tick();
        mif.mem_ack_i = 1'b0;
        check("idle_ack_state", {30'd0, state_o}, {30'd0, S_IDLE});
        check("idle_ack_rdata", rdata_o, 32'd0);

        // load, ack three cycles after req rises
        mem_op(1'b1, 1'b0, 3, 32'hDEAD_BEEF);
        check("load_rdata", rdata_o, 32'hDEAD_BEEF);
        // store, ack in first ACCESS cycle, rdata untouched
        mem_op(1'b0, 1'b1, 1, 32'h1234_5678);
        check("store_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        // both flags high acts as a store
        mem_op(1'b1, 1'b1, 2, 32'h0BAD_F00D);
        check("both_rdata_kept", rdata_o, 32'hDEAD_BEEF);

        // async reset in the middle of an access
        MemRead_i = 1'b1;
        tick();
        check("pre_rst_req", {31'd0, mif.mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mif.mem_req_o}, 32'd0);
        check("async_rst_state", {30'd0, state_o}, {30'd0, S_IDLE});
        check("async_rst_rdata", rdata_o, 32'd0);
        check("async_rst_we", {31'd0, mif.mem_we_o}, 32'd0);
        MemRead_i = 1'b0;
        tick();
        rst_i = 1'b1;
        exp_rd = 32'd0;
        #1;
        check("post_rst_pipe_en", {31'd0, pipe_en_o}, 32'd1);

        // no ack for 16 ACCESS cycles -> ERR
        MemRead_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("to_req_held", {31'd0, mif.mem_req_o}, 32'd1);
        end
        tick();
        check("to_state", {30'd0, state_o}, {30'd0, S_ERR});
        check("to_err", {31'd0, err_o}, 32'd1);
        check("to_req", {31'd0, mif.mem_req_o}, 32'd0);
        check("to_pipe_en", {31'd0, pipe_en_o}, 32'd0);
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'hFFFF_0000;
        tick();
        mif.mem_ack_i = 1'b0;
        check("err_late_ack_state", {30'd0, state_o}, {30'd0, S_ERR});
        check("err_late_ack_rdata", rdata_o, 32'd0);
        check("err_sticky", {31'd0, err_o}, 32'd1);
        MemRead_i = 1'b0;
        do_reset();

        // ack on the 16th ACCESS cycle still completes
        mem_op(1'b1, 1'b0, 16, 32'hCAFE_F00D);
        check("ack16_err", {31'd0, err_o}, 32'd0);
        check("ack16_rdata", rdata_o, 32'hCAFE_F00D);

        // start_i low while in DONE holds the pipeline
        MemRead_i = 1'b1;
        tick();
        tick();
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_0042;
        tick();
        mif.mem_ack_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_state", {30'd0, state_o}, {30'd0, S_DONE});
            check("hold_pipe_en", {31'd0, pipe_en_o}, 32'd0);
            check("hold_req", {31'd0, mif.mem_req_o}, 32'd0);
            tick();
        end
        start_i = 1'b1;
        #1;
        check("hold_release_pipe_en", {31'd0, pipe_en_o}, 32'd1);
        check("hold_rdata", rdata_o, 32'h0000_0042);
        tick();
        MemRead_i = 1'b0;
        #1;
        check("hold_release_idle", {30'd0, state_o}, {30'd0, S_IDLE});

        // stall counter: loads with k=2 and k=5 from a clean reset
        start_i = 1'b0;
        do_reset();
        start_i = 1'b1;
        mem_op(1'b1, 1'b0, 2, 32'h0000_0001);
        mem_op(1'b1, 1'b0, 5, 32'h0000_0002);
`ifdef MEM_STALL_PERF_EN
        check("stall_cnt", stall_cnt_o, 32'd9);
`else
        check("stall_cnt", stall_cnt_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
Sequences multi-cycle data-memory accesses in the MEM stage of the 5-stage pipeline. It detects a load or store in EX/MEM and drives the memory request. It also generates the shared pipeline-advance enable that feeds start_i of IF/ID, ID/EX, EX/MEM and MEM/WB, freezing all pipeline registers until memory acknowledges. Load data is captured into a hold register for MEM/WB.

Parameters:
DATA_W, 32, width of memory read data
TIMEOUT, 16, maximum ACCESS cycles before a bus error; must be >= 2
CNT_W, $clog2(TIMEOUT+1), access cycle counter width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  global run enable from CPU top
MemRead_i  input  1  EX/MEM load flag
MemWrite_i  input  1  EX/MEM store flag
mem_ack_i  input  1  memory completion, 1-cycle pulse
mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
mem_req_o  output  1  memory request, held until ack
mem_we_o  output  1  1 = store, 0 = load
pipe_en_o  output  1  pipeline advance enable to all pipeline registers
rdata_o  output  DATA_W  captured load data to MEM/WB data input
err_o  output  1  sticky bus-timeout flag
stall_cnt_o  output  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset (rst_i=0, async): state=IDLE, mem_req_o=0, mem_we_o=0, rdata_o=0, err_o=0, counter=0, stall_cnt_o=0. Reset mid-access abandons the request immediately.
- Define memop = MemRead_i | MemWrite_i.
- States: IDLE, ACCESS, DONE, ERR. Encoding is free. Registered outputs: mem_req_o, mem_we_o, rdata_o, err_o.
- pipe_en_o is combinational:
  - IDLE: start_i & ~memop
  - DONE: start_i
  - ACCESS and ERR: 0
- IDLE:
  - start_i & memop -> ACCESS. Set mem_req_o=1, latch mem_we_o=MemWrite_i, counter=0.
  - MemRead_i and MemWrite_i both high counts as a store.
  - start_i=0: no launch.
  - mem_ack_i is ignored in IDLE.
- ACCESS:
  - mem_req_o stays 1. Counter increments each cycle.
  - mem_ack_i=1 -> DONE, mem_req_o=0. If ~mem_we_o, rdata_o <= mem_rdata_i; otherwise rdata_o keeps its value.
  - Ack has priority over timeout.
  - No ack while counter==TIMEOUT-1 -> ERR, mem_req_o=0, err_o=1.
- DONE:
  - pipe_en_o=start_i.
  - start_i=1 -> IDLE. The pipeline advances on this edge, so the same op is never re-launched.
  - start_i=0 -> hold in DONE.
- ERR: terminal until reset. err_o stays 1, pipe_en_o stays 0.
- Latency: op visible in IDLE at cycle t, mem_req_o high from t+1, ack at t+k (k>=1), pipe_en_o=1 at t+k+1. Stall = k+1 cycles.
- Back-to-back memops: each pays the full sequence. DONE->IDLE takes 1 cycle, then a new launch.

Optional Feature:
MEM_STALL_PERF_EN.
- Defined: stall_cnt_o increments each cycle with start_i=1 & pipe_en_o=0. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is built. The port list is unchanged.

Test Plan:
- Reset mid-ACCESS with mem_req_o=1 -> all outputs 0 and state IDLE asynchronously; after release with no memop and start_i=1, pipe_en_o=1.
- Load, start_i=1, ack 3 cycles after req rises, mem_rdata_i=32'hDEADBEEF -> pipe_en_o low 4 cycles, then high 1 cycle; rdata_o=32'hDEADBEEF, mem_we_o=0.
- Store with ack in the first ACCESS cycle -> mem_we_o=1, stall exactly 2 cycles, rdata_o unchanged.
- No ack for 16 ACCESS cycles (TIMEOUT=16) -> ERR, err_o=1, mem_req_o=0; a later ack is ignored. Ack on the 16th cycle -> DONE, err_o=0.
- start_i=0 in DONE for 5 cycles -> remain DONE, pipe_en_o=0, no new request; start_i=1 -> pipe_en_o=1, then IDLE.
- MEM_STALL_PERF_EN defined, two loads with k=2 and k=5, start_i=1 throughout -> stall_cnt_o=9; undefined -> stall_cnt_o=0.
